// File: rtl/imem_loader_pkg.sv
// +----------------------------------------------------------------------+
// | Module   : imem_loader_pkg                                           |
// | Purpose  : Shared types and constants for the instruction RAM loader |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

package imem_loader_pkg;

    localparam int         c_WORD_W = 32;
    localparam logic [7:0] c_MAGIC  = 8'hA5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_loader_word_packer.sv
// +----------------------------------------------------------------------+
// | Module   : word_packer                                               |
// | Purpose  : Packs four big-endian stream bytes into one 32-bit word   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module word_packer
    import imem_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                byte_en,
    input  logic [7:0]          byte_in,
    output logic [c_WORD_W-1:0] word,
    output logic                word_valid
);

    logic [1:0]  r_idx;
    logic [23:0] r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= 2'd0;
            r_acc <= 24'd0;
        end else if (clr) begin
            r_idx <= 2'd0;
            r_acc <= 24'd0;
        end else if (byte_en) begin
            r_idx <= r_idx + 2'd1;
            r_acc <= {r_acc[15:0], byte_in};
        end
    end

    // The fourth byte completes the word combinationally so the parent can register it.
    assign word       = {r_acc, byte_in};
    assign word_valid = byte_en && (r_idx == 2'd3);

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// +----------------------------------------------------------------------+
// | Module   : imem_loader                                               |
// | Purpose  : Loads a framed byte stream into instruction RAM, releases |
// |            the CPU once the image checksum verifies                  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W    = 12,
    parameter int         BASE_ADDR = 0,
    parameter logic [7:0] MAGIC     = c_MAGIC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [c_WORD_W-1:0] mem_wdata,
    output logic                cpu_hold,
    output logic                done,
    output logic                error
);

    localparam logic [16:0]       c_MAX_WORDS = 17'((1 << ADDR_W) - BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_BASE      = ADDR_W'(BASE_ADDR);

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_len_hi;
    logic [15:0]         r_len;
    logic [15:0]         r_word_idx;
    logic [7:0]          r_csum;
    logic                w_accept;
    logic [15:0]         w_len_n;
    logic                w_too_long;
    logic                w_last_word;
    logic                w_word_valid;
    logic [c_WORD_W-1:0] w_word;

    assign in_ready    = (r_state != DONE) && (r_state != ERR);
    assign w_accept    = in_valid && in_ready;
    assign w_len_n     = {r_len_hi, in_data};
    assign w_too_long  = ({1'b0, w_len_n} > c_MAX_WORDS);
    assign w_last_word = (r_word_idx == (r_len - 16'd1));

    assign done     = (r_state == DONE);
    assign error    = (r_state == ERR);
    assign cpu_hold = (r_state != DONE);

    word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (r_state != DATA),
        .byte_en    (w_accept && (r_state == DATA)),
        .byte_in    (in_data),
        .word       (w_word),
        .word_valid (w_word_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (w_accept && (in_data == MAGIC)) w_next = LEN_HI;
            LEN_HI: if (w_accept) w_next = LEN_LO;
            LEN_LO: begin
                if (w_accept) begin
                    if (w_len_n == 16'd0) w_next = CSUM;
                    else if (w_too_long)  w_next = ERR;
                    else                  w_next = DATA;
                end
            end
            DATA:   if (w_word_valid && w_last_word) w_next = CSUM;
            CSUM:   if (w_accept) w_next = (in_data == r_csum) ? DONE : ERR;
            DONE:   if (start) w_next = IDLE;
            ERR:    if (start) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Memory-port registers hold between writes; only a completed word updates them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len_hi   <= 8'd0;
            r_len      <= 16'd0;
            r_word_idx <= 16'd0;
            r_csum     <= 8'd0;
            mem_we     <= 1'b0;
            mem_addr   <= c_BASE;
            mem_wdata  <= '0;
        end else begin
            mem_we <= w_word_valid;
            case (r_state)
                IDLE: begin
                    r_word_idx <= 16'd0;
                    r_csum     <= 8'd0;
                end
                LEN_HI: begin
                    if (w_accept) begin
                        r_len_hi <= in_data;
                        r_csum   <= r_csum ^ in_data;
                    end
                end
                LEN_LO: begin
                    if (w_accept) begin
                        r_len  <= w_len_n;
                        r_csum <= r_csum ^ in_data;
                    end
                end
                DATA: begin
                    if (w_accept) r_csum <= r_csum ^ in_data;
                    if (w_word_valid) begin
                        mem_addr   <= c_BASE + r_word_idx[ADDR_W-1:0];
                        mem_wdata  <= w_word;
                        r_word_idx <= r_word_idx + 16'd1;
                    end
                end
                DONE, ERR: begin
                    if (start) begin
                        r_word_idx <= 16'd0;
                        r_csum     <= 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
